// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the sequential shift-add multiplier: default datapath
// width and the FSM state encoding.
package mul_sequencer_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add iteration: conditionally accumulate the
// multiplicand, then shift multiplicand left and multiplier right.
module mul_step
    import mul_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0] i_mplier,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_mcand,
    output logic [XLEN-1:0] o_mplier
);

    // Sum wraps at XLEN bits, which gives the low half for signed and unsigned alike.
    assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand  = i_mcand << 1;
    assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiplier for the EX stage: stalls the upstream pipeline while
// shift-add steps run, terminating early once the remaining multiplier is zero.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_product;
    logic [XLEN-1:0]   w_step_acc;
    logic [XLEN-1:0]   w_step_mcand;
    logic [XLEN-1:0]   w_step_mplier;
    logic [CNT_W-1:0]  w_count_inc;

    mul_step #(.XLEN(XLEN)) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_step_acc),
        .o_mcand  (w_step_mcand),
        .o_mplier (w_step_mplier)
    );

    assign w_count_inc = r_count + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = (b == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if ((w_step_mplier == '0) || (w_count_inc == CNT_W'(XLEN)))
                         w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_acc    <= '0;
                    r_mcand  <= a;
                    r_mplier <= b;
                    r_count  <= '0;
                    if (b == '0) r_product <= '0;
                end
                ST_RUN: begin
                    r_acc    <= w_step_acc;
                    r_mcand  <= w_step_mcand;
                    r_mplier <= w_step_mplier;
                    r_count  <= w_count_inc;
                    // Product lands as DONE is entered so it is valid alongside done.
                    if (w_state_next == ST_DONE) r_product <= w_step_acc;
                end
                default: ;
            endcase
        end
    end

    // Reset gates start so the pipeline is never frozen while reset is held.
    assign stall   = ~reset & (((r_state == ST_IDLE) & start) | (r_state == ST_RUN));
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench: directed and random multiplies against a reference
// built from a*b modulo 2^64 and a latency of highest-set-bit-index + 2 cycles.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          total  = 0;
    int          passed = 0;
    logic [63:0] last_product = '0;

    mul_sequencer #(.XLEN(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int steps_of(input logic [63:0] v);
        int s = 0;
        for (int i = 0; i < 64; i++) if (v[i]) s = i + 1;
        return s;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One operation: start is driven in the IDLE cycle, then cycles are counted
    // until done; operands are scrambled after acceptance to prove they were captured.
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input bit hold);
        logic [63:0] exp_p;
        int          exp_lat;
        int          cyc;
        bit          got;
        exp_p   = av * bv;
        exp_lat = steps_of(bv) + 1;
        @(posedge clk); #1;
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        check("start_stall", stall, 1);
        check("start_busy", busy, 0);
        check("start_prod_hold", product, last_product);
        cyc = 0;
        got = 0;
        while (!got && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            start = hold;
            a = rand64();
            b = rand64();
            @(negedge clk);
            if (done) begin
                got = 1;
                check("latency", 64'(cyc), 64'(exp_lat));
                check("product", product, exp_p);
                check("done_stall", stall, 0);
                check("done_busy", busy, 1);
            end else begin
                check("run_busy", busy, 1);
                check("run_stall", stall, 1);
                check("run_prod_hold", product, last_product);
            end
        end
        if (!got) check("done_timeout", 0, 1);
        last_product = exp_p;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a = 64'd3; b = 64'd5;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);

        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_stall", stall, 0);

        run_op(64'd3, 64'd5, 0);
        run_op(64'h1234, 64'd0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
        run_op(-64'sd7, 64'd6, 0);
        check("neg_result", last_product, 64'hFFFF_FFFF_FFFF_FFD6);

        for (int i = 0; i < 8; i++) begin
            logic [63:0] rb;
            rb = rand64() >> $urandom_range(0, 63);
            run_op(rand64(), rb, 0);
        end

        // Abort mid-run with reset; no done may escape and a fresh op must follow.
        @(posedge clk); #1;
        start = 1'b1; a = 64'd9; b = 64'hFF;
        @(posedge clk); #1;
        start = 1'b0; a = rand64(); b = rand64();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_stall", stall, 0);
        check("abort_product", product, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_done", done, 0);
            check("post_abort_busy", busy, 0);
        end
        last_product = '0;
        run_op(64'd2, 64'd3, 0);

        // Start held high: back-to-back operations every five cycles.
        for (int i = 0; i < 3; i++) run_op(64'd4, 64'd4, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("final_idle_busy", busy, 0);
        check("final_prod_hold", product, 64'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
